// File: rtl/register_16b_pkg.sv
// Shared datapath types and constants for the processor's storage registers.
package register_16b_pkg;

  localparam int DATA_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0] data_word_t;

  localparam data_word_t RESET_VALUE_DEFAULT = 16'h0000;

endpackage

// File: rtl/register_16b.sv
// Edge-triggered storage register with write enable and async active-high reset.
// Reused for register-file entries, PC, IR and pipeline stages.
module register_16b
  import register_16b_pkg::*;
#(
  parameter int                 WIDTH       = DATA_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VALUE = WIDTH'(RESET_VALUE_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             w_flag,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] data_q;

  // Reset clears immediately and blocks writes while held; release needs no action here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RESET_VALUE;
    end else if (w_flag) begin
      data_q <= in;
    end
  end

  assign out = data_q;

endmodule

// File: tb/tb_register_16b.sv
// Scoreboard bench for register_16b: expected values are queued as stimulus is
// driven and popped when the register output is sampled.
module tb_register_16b;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_d;
  logic        w_flag;
  logic [15:0] out_d;

  logic [15:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  register_16b dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in_d),
    .w_flag (w_flag),
    .out    (out_d)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic w, input logic [15:0] d);
    @(negedge clk);
    rst    = r;
    w_flag = w;
    in_d   = d;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    @(negedge clk);
    in_d   = 16'hFFFF;
    w_flag = 1'b1;
    #1 rst = 1'b1;
    exp_q.push_back(16'h0000);
    #1;
    exp = exp_q.pop_front();
    compared++;
    if (out_d !== exp) begin
      mismatched++;
      $display("FAIL reset_async: out=%h expected=%h", out_d, exp);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(16'h0000);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      compared++;
      if (out_d !== exp) begin
        mismatched++;
        $display("FAIL reset_held_%0d: out=%h expected=%h", i, out_d, exp);
      end
    end
  endtask

  task automatic test_write();
    logic [15:0] exp;
    logic [15:0] vals[2] = '{16'hAA55, 16'hFF00};
    foreach (vals[i]) begin
      drive(1'b0, 1'b1, vals[i]);
      exp_q.push_back(vals[i]);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      compared++;
      if (out_d !== exp) begin
        mismatched++;
        $display("FAIL write_%0d: out=%h expected=%h", i, out_d, exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [15:0] exp;
    drive(1'b0, 1'b0, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(16'hFF00);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      compared++;
      if (out_d !== exp) begin
        mismatched++;
        $display("FAIL hold_ffff_%0d: out=%h expected=%h", i, out_d, exp);
      end
    end
    drive(1'b0, 1'b0, 16'hF0F0);
    exp_q.push_back(16'hFF00);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    compared++;
    if (out_d !== exp) begin
      mismatched++;
      $display("FAIL hold_f0f0: out=%h expected=%h", out_d, exp);
    end
  endtask

  task automatic test_no_edge();
    logic [15:0] exp;
    drive(1'b0, 1'b1, 16'h1111);
    #1 in_d = 16'h1234;
    exp_q.push_back(16'hFF00);
    #1;
    exp = exp_q.pop_front();
    compared++;
    if (out_d !== exp) begin
      mismatched++;
      $display("FAIL no_edge_between: out=%h expected=%h", out_d, exp);
    end
    exp_q.push_back(16'h1234);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    compared++;
    if (out_d !== exp) begin
      mismatched++;
      $display("FAIL no_edge_after: out=%h expected=%h", out_d, exp);
    end
  endtask

  task automatic test_reset_priority();
    logic [15:0] exp;
    drive(1'b1, 1'b1, 16'h5678);
    exp_q.push_back(16'h0000);
    #1;
    exp = exp_q.pop_front();
    compared++;
    if (out_d !== exp) begin
      mismatched++;
      $display("FAIL prio_async: out=%h expected=%h", out_d, exp);
    end
    exp_q.push_back(16'h0000);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    compared++;
    if (out_d !== exp) begin
      mismatched++;
      $display("FAIL prio_edge: out=%h expected=%h", out_d, exp);
    end
    drive(1'b0, 1'b1, 16'h5678);
    exp_q.push_back(16'h5678);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    compared++;
    if (out_d !== exp) begin
      mismatched++;
      $display("FAIL prio_release: out=%h expected=%h", out_d, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    logic [15:0] vals[3] = '{16'h0001, 16'h8000, 16'h7FFF};
    foreach (vals[i]) begin
      drive(1'b0, 1'b1, vals[i]);
      exp_q.push_back(vals[i]);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      compared++;
      if (out_d !== exp) begin
        mismatched++;
        $display("FAIL b2b_%0d: out=%h expected=%h", i, out_d, exp);
      end
    end
    drive(1'b0, 1'b0, 16'h0000);
    exp_q.push_back(16'h7FFF);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    compared++;
    if (out_d !== exp) begin
      mismatched++;
      $display("FAIL b2b_hold: out=%h expected=%h", out_d, exp);
    end
  endtask

  initial begin
    rst    = 1'b0;
    w_flag = 1'b0;
    in_d   = 16'h0000;
    test_reset();
    test_write();
    test_hold();
    test_no_edge();
    test_reset_priority();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/register_16b.md
Name: register_16b

Overview:
- General-purpose 16-bit storage register with a write enable, used as a register-file/pipeline building block in the CSSE232 processor datapath.
- Captures `in` on the rising clock edge when `w_flag` is high. Otherwise holds its value.
- `out` continuously drives the stored value.
- Asynchronous active-high reset forces a known value.

Parameters:
- WIDTH, 16, data width in bits. The processor uses only 16; other values are legal for reuse.
- RESET_VALUE, 16'h0000 (WIDTH bits, all zero), value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on its rising edge except reset.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  data to be written.
- w_flag  input  1  write enable, active-high, sampled on rising clk.
- out  output  WIDTH  current stored value.

Behaviour:
- Reset:
  - rst=1 immediately (no clock needed) sets stored value to RESET_VALUE; out=0x0000 by default.
  - While rst is held high, writes are ignored.
  - Deassertion is used synchronously by the surrounding design. The register takes no action on the release edge.
- Write: on rising clk with rst=0 and w_flag=1, stored value <= in. Visible on out after the edge (one-edge latency, no combinational in→out path).
- Hold: on rising clk with w_flag=0, stored value is unchanged regardless of `in`.
- `in` and `w_flag` changes between clock edges have no effect on out. The block is fully edge-triggered, not a latch.
- Simultaneous rst=1 and w_flag=1 at a clock edge: reset wins.
- Reset mid-operation: asynchronous clear overrides any pending write; the next write occurs on the first rising edge with rst=0 and w_flag=1.
- Back-to-back writes on consecutive edges are each captured; out tracks in with one-cycle lag.
- out is a registered output driven only by the storage flops. No X after reset; X on `in` propagates only when written.
- Power-up without reset is undefined. The system must assert rst before use.

Decomposition:
- Shared package: DATA_WIDTH=16 constant and a data_word_t typedef (logic [15:0]) used across datapath registers; RESET_VALUE default defined there as 16'h0000.
- No sub-module. A single always block with async reset is natural.
- The register file instantiates this block per register; the PC, IR and pipeline registers reuse it.

Test Plan:
- Reset: drive in=0xFFFF, w_flag=1, assert rst with no clock edge -> out=0x0000 immediately. Hold rst over 2 edges -> out stays 0x0000.
- Write enabled: rst=0, in=0xAA55, w_flag=1, one rising edge -> out=0xAA55. Then in=0xFF00, w_flag=1, one edge -> out=0xFF00.
- Write disabled: from out=0xFF00, in=0xFFFF, w_flag=0, several edges -> out=0xFF00. Then in=0xF0F0, w_flag=0 -> out=0xFF00.
- No clock edge: w_flag=1, change in to 0x1234 between edges -> out unchanged until the next rising edge, then 0x1234.
- Reset priority: out=0x1234, assert rst together with w_flag=1, in=0x5678 across an edge -> out=0x0000. Release rst, one edge with w_flag=1 -> out=0x5678.
- Back-to-back: w_flag=1, in sequence 0x0001, 0x8000, 0x7FFF on consecutive edges -> out follows one cycle later, exactly those values.
